// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU round-robin scheduler slice:
//   - opcode encodings understood by the external Simple_ALU
//   - ALU datapath width
//   - scheduler FSM state type
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_LSR = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;
    localparam logic [2:0] ALU_EQL = 3'b111;

    localparam int ALU_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one position
// after the previous winner and wraps, so the previous winner has the
// lowest priority.
// Ports:
//   req        in   N      request vector
//   last       in   IDX_W  index of the previous winner
//   grant      out  N      one-hot grant (all zero when no request)
//   grant_idx  out  IDX_W  index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    int               cand;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        idx       = '0;
        // Offsets 1..N visit every requester once, ending on 'last' itself.
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            idx  = IDX_W'(cand);
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// ---------------------------------------------------------------------------
// alu_rr_sched
// Shares one external combinational ALU between NUM_REQ requesters with a
// single outstanding transaction: IDLE (arbitrate/accept) -> EXEC (operands
// presented to the ALU for one cycle) -> RESP (result held until consumed).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and operands stable until accepted and may
// drop valid before that with no effect. The response is held stable while
// rsp_valid_o is high until rsp_ready_i is seen high at an edge.
//
// Optional build macro ALU_RR_SCHED_PERF_EN adds per-requester saturating
// 8-bit grant counters (grant_cnt_o) and their synchronous clear (clr_cnt_i).
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_valid_i/req_ready_o  per-requester request handshake (ready one-hot)
//   req_a_i/req_b_i/req_op_i packed operands/opcode, requester k at slice k
//   alu_a_o/alu_b_o/alu_op_o operands to the ALU (registered)
//   alu_res_i                result from the ALU
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_id_o/rsp_data_o      owner index and ALU result
//   clr_cnt_i/grant_cnt_o    (macro only) counter clear / packed counters
//   dbg_state_o              current FSM state for observation
// ---------------------------------------------------------------------------
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DATA_W  = ALU_DATA_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*3-1:0]      req_op_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]         alu_a_o,
    output logic [DATA_W-1:0]         alu_b_o,
    output logic [2:0]                alu_op_o,
    input  logic [DATA_W-1:0]         alu_res_i,
    output logic                      rsp_valid_o,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    input  logic                      rsp_ready_i,
`ifdef ALU_RR_SCHED_PERF_EN
    input  logic                      clr_cnt_i,
    output logic [NUM_REQ*8-1:0]      grant_cnt_o,
`endif
    output sched_state_e              dbg_state_o
);

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     op_id_q;
    logic [DATA_W-1:0]   op_a_q, op_b_q;
    logic [2:0]          op_op_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     grant_idx;
    logic                accept;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req       (req_valid_i),
        .last      (last_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = EXEC;
            EXEC:                     state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready_o = (state_q == IDLE) ? grant : '0;
        rsp_valid_o = (state_q == RESP);
    end

    // The arbiter only grants a valid requester, so any ready bit means accept.
    assign accept = |(req_valid_i & req_ready_o);

    // Operand capture, pointer update and result sampling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_op_q    <= '0;
            op_id_q    <= '0;
            last_q     <= ID_W'(NUM_REQ - 1);
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                op_a_q  <= req_a_i[grant_idx*DATA_W +: DATA_W];
                op_b_q  <= req_b_i[grant_idx*DATA_W +: DATA_W];
                op_op_q <= req_op_i[grant_idx*3 +: 3];
                op_id_q <= grant_idx;
                last_q  <= grant_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_res_i;
                rsp_id_q   <= op_id_q;
            end
        end
    end

    assign alu_a_o     = op_a_q;
    assign alu_b_o     = op_b_q;
    assign alu_op_o    = op_op_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign dbg_state_o = state_q;

`ifdef ALU_RR_SCHED_PERF_EN
    logic [7:0] cnt_q [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q[k] <= '0;
            end else if (clr_cnt_i) begin
                cnt_q[k] <= '0;
            end else if (accept && grant[k] && (cnt_q[k] != 8'hFF)) begin
                cnt_q[k] <= cnt_q[k] + 8'd1;
            end
        end
        assign grant_cnt_o[k*8 +: 8] = cnt_q[k];
    end
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_sched
// Bench for alu_rr_sched with a behavioural stand-in for Simple_ALU on the
// alu_* ports. A transaction-level model (rotating-priority search, queue of
// expected responses, cycle age of the outstanding transaction) predicts
// every observable output each cycle. Build with ALU_RR_SCHED_PERF_EN defined
// to also exercise the grant counters.
// ---------------------------------------------------------------------------
module tb_alu_rr_sched;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DATA_W  = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a, req_b;
  logic [NUM_REQ*3-1:0]      req_op;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         alu_a, alu_b, alu_res, rsp_data;
  logic [2:0]                alu_op;
  logic                      rsp_valid, rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  sched_state_e              dbg_state;
`ifdef ALU_RR_SCHED_PERF_EN
  logic                      clr_cnt = 1'b0;
  logic [NUM_REQ*8-1:0]      grant_cnt;
`endif

  alu_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_op_i    (req_op),
    .req_ready_o (req_ready),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_res_i   (alu_res),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
`ifdef ALU_RR_SCHED_PERF_EN
    .clr_cnt_i   (clr_cnt),
    .grant_cnt_o (grant_cnt),
`endif
    .dbg_state_o (dbg_state)
  );

  // Simple_ALU behaviour
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
    case (op)
      ALU_ADD: alu_ref = a + b;
      ALU_SUB: alu_ref = a - b;
      ALU_SLL: alu_ref = a << b;
      ALU_LSR: alu_ref = a >> b;
      ALU_AND: alu_ref = a & b;
      ALU_OR:  alu_ref = a | b;
      ALU_XOR: alu_ref = a ^ b;
      default: alu_ref = (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_comb alu_res = alu_ref(alu_a, alu_b, alu_op);

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [ID_W+DATA_W-1:0] exp_q[$];
  logic [ID_W+DATA_W-1:0] rsp_log[$];
  int                     grant_log[$];
  int                     m_last;
  bit                     m_busy;
  int                     m_age;
  logic [7:0]             m_a, m_b;
  logic [2:0]             m_op;
  int                     m_cnt[NUM_REQ];
  int                     n_rsp = 0;

  // ---------------- driver state ----------------
  bit         dv[NUM_REQ];
  logic [7:0] da[NUM_REQ], db[NUM_REQ];
  logic [2:0] dop[NUM_REQ];
  int         refill[NUM_REQ];
  bit         rand_mode = 1'b0;

  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid[k]          = dv[k];
      req_a[k*DATA_W +: 8]  = da[k];
      req_b[k*DATA_W +: 8]  = db[k];
      req_op[k*3 +: 3]      = dop[k];
    end
  endtask

  task automatic post(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    dv[k] = 1'b1; da[k] = a; db[k] = b; dop[k] = op;
    drive();
  endtask

  task automatic post_random(input int k);
    post(k, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
  endtask

  // Rotating priority: first valid requester after the previous winner.
  function automatic int model_pick();
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (dv[(m_last + i) % NUM_REQ]) return (m_last + i) % NUM_REQ;
    end
    return -1;
  endfunction

  // One clock: check at the falling edge, update model, advance, re-drive.
  task automatic tick();
    logic [NUM_REQ-1:0] exp_ready;
    int g;
    int acc;
    acc = -1;
    @(negedge clk);
    g = model_pick();
    exp_ready = '0;
    if (!m_busy && g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
    check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
    if (m_busy && m_age == 1) begin
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_op", 32'(alu_op), 32'(m_op));
    end
    if (m_busy && m_age >= 2) begin
      check("rsp_id", 32'(rsp_id), 32'(exp_q[0][DATA_W +: ID_W]));
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0][DATA_W-1:0]));
      if (rsp_ready) begin
        rsp_log.push_back({rsp_id, rsp_data});
        void'(exp_q.pop_front());
        m_busy = 1'b0;
        n_rsp++;
      end
    end
`ifdef ALU_RR_SCHED_PERF_EN
    for (int k = 0; k < NUM_REQ; k++)
      check("grant_cnt", 32'(grant_cnt[k*8 +: 8]), 32'(m_cnt[k]));
`endif
    if (exp_ready != '0) begin
      acc    = g;
      m_last = g;
      m_busy = 1'b1;
      m_age  = 0;
      m_a = da[g]; m_b = db[g]; m_op = dop[g];
      exp_q.push_back({ID_W'(g), alu_ref(da[g], db[g], dop[g])});
      grant_log.push_back(g);
      if (m_cnt[g] < 255) m_cnt[g]++;
    end
    @(posedge clk);
    if (m_busy) m_age++;
`ifdef ALU_RR_SCHED_PERF_EN
    if (clr_cnt) for (int k = 0; k < NUM_REQ; k++) m_cnt[k] = 0;
`endif
    #1;
    if (acc >= 0) begin
      if (refill[acc] > 0) begin
        refill[acc]--;
        post_random(acc);
      end else begin
        dv[acc] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (!dv[k] && $urandom_range(0, 2) == 0) post_random(k);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drive();
  endtask

  function automatic bit any_pending();
    for (int k = 0; k < NUM_REQ; k++) if (dv[k]) return 1'b1;
    return m_busy;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (any_pending() && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(any_pending()), 32'd0);
  endtask

  task automatic wait_age(input string tag, input int age, input int budget);
    int n;
    n = 0;
    while (!(m_busy && m_age == age) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(m_busy && m_age == age), 32'd1);
  endtask

  // Asynchronous reset: outputs must clear immediately, model forgets all.
  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin dv[k] = 1'b0; refill[k] = 0; m_cnt[k] = 0; end
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    drive();
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef ALU_RR_SCHED_PERF_EN
    check("rst_grant_cnt", 32'(grant_cnt), 32'd0);
`endif
    m_last = NUM_REQ - 1;
    m_busy = 1'b0;
    m_age  = 0;
    exp_q.delete();
    grant_log.delete();
    rsp_log.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  int nb;

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin da[k] = '0; db[k] = '0; dop[k] = '0; end
    do_reset();

    // Single request: ADD 10,5 -> (0, 15)
    post(0, 8'd10, 8'd5, ALU_ADD);
    drain("single_drain", 20);
    check("single_count", 32'(rsp_log.size()), 32'd1);
    check("single_rsp", 32'(rsp_log[0]), 32'({2'd0, 8'd15}));

    // Contention from reset: 0 then 2
    do_reset();
    post(0, 8'd20, 8'd5, ALU_SUB);
    post(2, 8'hAA, 8'h55, ALU_XOR);
    drain("cont_drain", 30);
    check("cont_grant0", 32'(grant_log[0]), 32'd0);
    check("cont_grant1", 32'(grant_log[1]), 32'd2);
    check("cont_rsp0", 32'(rsp_log[0]), 32'({2'd0, 8'd15}));
    check("cont_rsp1", 32'(rsp_log[1]), 32'({2'd2, 8'hFF}));

    // Fairness: all four continuously valid for two rounds (wrap 3 -> 0)
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) begin refill[k] = 1; post_random(k); end
    drain("fair_drain", 60);
    check("fair_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) check("fair_order", 32'(grant_log[i]), 32'(i % NUM_REQ));

    // Backpressure: SLL 8,1 held for 5 cycles, another requester waiting
    rsp_log.delete();
    rsp_ready = 1'b0;
    post(3, 8'd8, 8'd1, ALU_SLL);
    wait_age("bp_wait", 2, 10);
    post(0, 8'd1, 8'd2, ALU_ADD);
    nb = n_rsp;
    repeat (5) tick();
    check("bp_no_rsp", 32'(n_rsp), 32'(nb));
    check("bp_data", 32'(rsp_data), 32'd16);
    check("bp_ready", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    drain("bp_drain", 20);
    check("bp_count", 32'(rsp_log.size()), 32'd2);
    check("bp_rsp0", 32'(rsp_log[0]), 32'({2'd3, 8'd16}));
    check("bp_rsp1", 32'(rsp_log[1]), 32'({2'd0, 8'd3}));

    // Randomised traffic with random response backpressure
    rand_mode = 1'b1;
    repeat (400) tick();
    rand_mode = 1'b0;
    rsp_ready = 1'b1;
    drive();
    drain("rand_drain", 200);
    check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset while in EXEC: transaction dropped, pointer back to NUM_REQ-1
    do_reset();
    post(1, 8'd7, 8'd9, ALU_ADD);
    wait_age("exec_wait", 1, 10);
    check("exec_state", 32'(dbg_state), 32'(EXEC));
    nb = n_rsp;
    do_reset();
    repeat (3) tick();
    check("exec_no_rsp", 32'(n_rsp), 32'(nb));
    post(2, 8'd3, 8'd3, ALU_EQL);
    post(0, 8'd1, 8'd1, ALU_OR);
    drain("exec_drain", 20);
    check("exec_next_grant", 32'(grant_log[0]), 32'd0);
    check("exec_rsp0", 32'(rsp_log[0]), 32'({2'd0, 8'd1}));

`ifdef ALU_RR_SCHED_PERF_EN
    // Saturation after 300 grants to requester 1, then clear
    do_reset();
    refill[1] = 299;
    post_random(1);
    drain("perf_drain", 1500);
    check("perf_sat", 32'(grant_cnt[15:8]), 32'd255);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("perf_clr", 32'(grant_cnt[15:8]), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
- Round-robin scheduler that shares one combinational Simple_ALU (8-bit operands, 3-bit op) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel. The block keeps a single outstanding transaction, registers the operands, samples the ALU result and returns it on a shared response channel tagged with the requester ID.
- It sits between client units and the ALU instance; the ALU sits outside this block, wired to the alu_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- DATA_W, 8, operand/result width; must match the ALU.

Ports:
- clk_i  input  1  clock; all state is on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_a_i  input  NUM_REQ*DATA_W  packed operand A; requester k uses bits [k*DATA_W +: DATA_W].
- req_b_i  input  NUM_REQ*DATA_W  packed operand B, same packing.
- req_op_i  input  NUM_REQ*3  packed opcode, 3 bits per requester.
- req_ready_o  output  NUM_REQ  one-hot accept; at most one bit high.
- alu_a_o  output  DATA_W  to ALU a_i.
- alu_b_o  output  DATA_W  to ALU b_i.
- alu_op_o  output  3  to ALU op_i.
- alu_res_i  input  DATA_W  from ALU alu_o.
- rsp_valid_o  output  1  response valid.
- rsp_id_o  output  ID_W  index of the requester that owns the response.
- rsp_data_o  output  DATA_W  ALU result.
- rsp_ready_i  input  1  response consumer ready.

Behaviour:
- Clock and reset:
  - Single clock clk_i.
  - rst_ni is asynchronous assert, active-low. Deassertion is synchronised externally.
- Reset values:
  - State = IDLE.
  - req_ready_o = 0, rsp_valid_o = 0, rsp_id_o = 0, rsp_data_o = 0.
  - alu_a_o, alu_b_o, alu_op_o = 0.
  - Round-robin pointer last_q = NUM_REQ-1, so requester 0 has first priority.
- State machine:
  - IDLE:
    - Grant = first k with req_valid_i[k]=1, searching (last_q+1) mod NUM_REQ upward with wrap.
    - req_ready_o = onehot(grant), combinational from req_valid_i and last_q; all zero if no valid.
    - On accept (valid & ready): capture a/b/op/id into operand regs, last_q <= grant, go to EXEC.
  - EXEC (1 cycle): alu_*_o are driven from the operand regs (registered, stable the whole cycle). At the clock edge, rsp_data_o <= alu_res_i and rsp_id_o <= id; go to RESP.
  - RESP: rsp_valid_o = 1. rsp_id_o and rsp_data_o stay stable until rsp_ready_i=1; then go to IDLE.
- Timing:
  - Latency: accept at edge N, rsp_valid_o high from cycle N+2.
  - Minimum issue interval is 3 cycles.
- Handshake rules:
  - req_ready_o is 0 outside IDLE.
  - Requesters hold valid and operands until accepted; dropping valid before accept is legal (no grant, no side effect).
- Boundary conditions:
  - Simultaneous requests: exactly one grant, by the rotating rule. A requester that stays valid is served within NUM_REQ grants.
  - Pointer wraps at NUM_REQ-1 -> 0.
  - Response backpressure: the block stalls in RESP indefinitely; no further accepts.
  - Reset mid-operation (EXEC or RESP): the transaction is discarded, no response is issued, and the pointer returns to NUM_REQ-1.
- Arithmetic: operands and opcode pass through unmodified; the result width is DATA_W with no extension.

Optional Feature:
- Macro: ALU_RR_SCHED_PERF_EN.
- Defined:
  - Adds output port grant_cnt_o, NUM_REQ*8 bits: one 8-bit counter per requester.
  - A requester's counter increments on each accept for that requester and saturates at 255.
  - Counters reset to 0.
  - Adds input clr_cnt_i, 1 bit: synchronous clear of all counters. Clear wins over a same-cycle increment.
- Undefined: neither port exists and there is no counter logic. Scheduling behaviour is identical either way.

Decomposition:
- Package alu_pkg:
  - Opcode localparams ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_SLL=3'b010, ALU_LSR=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110, ALU_EQL=3'b111.
  - ALU_DATA_W=8.
  - Scheduler state enum {IDLE, EXEC, RESP}.
- Sub-module rr_arbiter (param N):
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, grant index.
  - Purely combinational.

Test Plan:
- Setup: the bench instantiates Simple_ALU on the alu_* ports.
- Single request: req0 a=10, b=5, op=000. Accept at cycle 0; rsp_valid_o at cycle 2 with id=0, data=15.
- Contention: req0 and req2 both valid from reset with SUB 20,5 and XOR AA,55. Grants go to 0 then 2; responses are (0, 8'd15) then (2, 8'hFF).
- Fairness: all 4 requesters valid continuously with 8 transactions. Grant order is 0,1,2,3,0,1,2,3; every req_ready_o is one-hot.
- Backpressure: rsp_ready_i held low for 5 cycles on SLL 8,1. rsp_data_o stays 8'd16 and stable; req_ready_o stays 0; a single response is delivered after release.
- Reset mid-EXEC: assert rst_ni low during EXEC. All outputs go to 0 immediately; no response is issued; the next grant goes to requester 0.
- With ALU_RR_SCHED_PERF_EN: 300 grants to requester 1. grant_cnt_o[15:8]=255; clr_cnt_i then returns it to 0.
